fpu_issue_sequencer: RTL and testbench
======================================

FPU_ISSUE_SEQUENCER -- requirements
Module: fpu_issue_sequencer

Interface
REQ-001 SHALL have parameter LAT_ADD, default 2: cycles from issue to writeback for fadd/fsub.
REQ-002 SHALL have parameter LAT_MUL, default 3: issue-to-writeback cycles for fmul.
REQ-003 SHALL have parameter LAT_DIV, default 12: issue-to-writeback cycles for fdiv.
REQ-004 SHALL have parameter LAT_SQRT, default 16: issue-to-writeback cycles for fsqrt; every LAT_* SHALL be 2..31.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have ports fadd, fsub, fmul, fdiv, fsqrt, input, 1 each: decoded FP op flags from the control unit.
REQ-008 SHALL have port issue_valid, input, 1: decode-stage instruction valid.
REQ-009 SHALL have port rd, input, 5: destination FP register of the presented op.
REQ-010 SHALL have port flush, input, 1: kill presented and in-flight FP op.
REQ-011 SHALL have port stall, output, 1: hold decode stage.
REQ-012 SHALL have port fpu_start, output, 1: one-cycle start pulse to the FP datapath.
REQ-013 SHALL have port fpu_op, output, 3: latched op code (0 add, 1 sub, 2 mul, 3 div, 4 sqrt).
REQ-014 SHALL have port busy, output, 1: high in EXEC.
REQ-015 SHALL have ports wb_valid, output, 1, and wb_rd, output, 5: FP register-file write strobe and address.

Function
REQ-016 SHALL implement states IDLE, EXEC, WB.
REQ-017 Request SHALL mean issue_valid & (any op flag); multiple flags SHALL resolve by priority fdiv > fsqrt > fmul > fsub > fadd.
REQ-018 In IDLE or WB, a request with flush low SHALL be accepted: fpu_start=1 that cycle, fpu_op and wb_rd latched next edge, counter loaded LAT-1, next state EXEC.
REQ-019 In EXEC the counter SHALL decrement each cycle; at counter==1 next state SHALL be WB.
REQ-020 wb_valid SHALL be high exactly LAT cycles after the issue cycle, for exactly one cycle, with wb_rd equal to the issued rd.
REQ-021 In WB with no acceptable request, next state SHALL be IDLE; with one, back-to-back issue per REQ-018 (wb_valid and fpu_start both high that cycle).
REQ-022 stall SHALL be combinational: high iff a request is presented while state is EXEC and flush is low.
REQ-023 Non-FP instructions (no op flag) SHALL never cause stall.
REQ-024 flush in EXEC SHALL return to IDLE next edge, suppressing wb_valid; flush in WB SHALL not suppress the current wb_valid but SHALL block a same-cycle issue.
REQ-025 flush in the issue cycle SHALL suppress fpu_start and leave state unchanged.
REQ-026 fpu_op and wb_rd SHALL hold their latched values until the next accepted issue.

Reset
REQ-027 rst high SHALL force state IDLE, counter 0, fpu_op 0, wb_rd 0 asynchronously.
REQ-028 During and after reset, stall, fpu_start, busy, wb_valid SHALL be 0 until a request is accepted.
REQ-029 Reset mid-EXEC SHALL abort the op with no wb_valid.

Structure
REQ-030 A shared package fpu_pkg SHALL hold op-code constants, the state enumeration, and default latency constants.
REQ-031 One sub-module fpu_lat_counter (5-bit loadable down-counter with load, en, zero-detect) SHALL be used.

Verification
REQ-032 Reset then fadd, rd=5 at cycle 0 -> fpu_start at cycle 0, fpu_op=0, wb_valid with wb_rd=5 at cycle 2 only.
REQ-033 fdiv rd=7 at cycle 0, fmul presented at cycles 1..11 -> stall high cycles 1..11, wb_valid rd=7 at cycle 12 with fpu_start (fmul) same cycle, fmul wb at cycle 15.
REQ-034 fmul and fdiv flags both high -> fpu_op=3, wb at LAT_DIV=12.
REQ-035 fsqrt at cycle 0, flush at cycle 5 -> state IDLE at cycle 6, no wb_valid at cycle 16.
REQ-036 rst asserted at cycle 4 of fdiv -> all outputs 0 immediately, no wb_valid; fadd after release completes in 2 cycles.
REQ-037 Integer instruction (no flags, issue_valid=1) during EXEC -> stall stays 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared op codes, sequencer states and default latencies
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;

    localparam int DEF_LAT_ADD  = 2;
    localparam int DEF_LAT_MUL  = 3;
    localparam int DEF_LAT_DIV  = 12;
    localparam int DEF_LAT_SQRT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Long-latency ops win when the decoder raises several flags at once.
    function automatic logic [2:0] op_select(
        input logic fadd,
        input logic fsub,
        input logic fmul,
        input logic fdiv,
        input logic fsqrt
    );
        logic [2:0] op;
        op = OP_ADD;
        if (fdiv)       op = OP_DIV;
        else if (fsqrt) op = OP_SQRT;
        else if (fmul)  op = OP_MUL;
        else if (fsub)  op = OP_SUB;
        else if (fadd)  op = OP_ADD;
        return op;
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// rtl/fpu_lat_counter.sv - 5-bit loadable down-counter with zero detect
module fpu_lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [4:0] load_val,
    output logic [4:0] count,
    output logic       zero
);

    logic [4:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 5'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != 5'd0)) begin
            count_q <= count_q - 5'd1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == 5'd0);

endmodule

// File: rtl/fpu_issue_sequencer.sv
// rtl/fpu_issue_sequencer.sv - single-issue FP sequencer: start pulse, stall and timed writeback
module fpu_issue_sequencer
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = DEF_LAT_ADD,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV,
    parameter int LAT_SQRT = DEF_LAT_SQRT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fadd,
    input  logic       fsub,
    input  logic       fmul,
    input  logic       fdiv,
    input  logic       fsqrt,
    input  logic       issue_valid,
    input  logic [4:0] rd,
    input  logic       flush,
    output logic       stall,
    output logic       fpu_start,
    output logic [2:0] fpu_op,
    output logic       busy,
    output logic       wb_valid,
    output logic [4:0] wb_rd
);

    localparam logic [4:0] LD_ADD  = 5'(LAT_ADD - 1);
    localparam logic [4:0] LD_MUL  = 5'(LAT_MUL - 1);
    localparam logic [4:0] LD_DIV  = 5'(LAT_DIV - 1);
    localparam logic [4:0] LD_SQRT = 5'(LAT_SQRT - 1);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [4:0] rd_q, rd_d;
    logic       req;
    logic [2:0] new_op;
    logic [4:0] load_val;
    logic       cnt_load;
    logic       cnt_en;
    logic [4:0] cnt;
    logic       cnt_zero;

    assign req    = issue_valid & (fadd | fsub | fmul | fdiv | fsqrt);
    assign new_op = op_select(fadd, fsub, fmul, fdiv, fsqrt);

    always_comb begin
        load_val = LD_ADD;
        case (new_op)
            OP_MUL:  load_val = LD_MUL;
            OP_DIV:  load_val = LD_DIV;
            OP_SQRT: load_val = LD_SQRT;
            default: load_val = LD_ADD;
        endcase
    end

    fpu_lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (load_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        fpu_start = 1'b0;
        stall     = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_WB: begin
                // WB doubles as an issue slot so ops can go back-to-back.
                if (req && !flush) begin
                    fpu_start = 1'b1;
                    op_d      = new_op;
                    rd_d      = rd;
                    cnt_load  = 1'b1;
                    state_d   = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cnt_en = 1'b1;
                stall  = req & ~flush;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if ((cnt == 5'd1) || cnt_zero) begin
                    state_d = ST_WB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_EXEC);
    assign wb_valid = (state_q == ST_WB);
    assign wb_rd    = rd_q;
    assign fpu_op   = op_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// tb/tb_fpu_issue_sequencer.sv - scoreboard bench for fpu_issue_sequencer
module tb_fpu_issue_sequencer;

    localparam logic [4:0] F_ADD  = 5'b00001;
    localparam logic [4:0] F_SUB  = 5'b00010;
    localparam logic [4:0] F_MUL  = 5'b00100;
    localparam logic [4:0] F_DIV  = 5'b01000;
    localparam logic [4:0] F_SQRT = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fadd = 1'b0, fsub = 1'b0, fmul = 1'b0, fdiv = 1'b0, fsqrt = 1'b0;
    logic       issue_valid = 1'b0;
    logic [4:0] rd = 5'd0;
    logic       flush = 1'b0;
    logic       stall, fpu_start, busy, wb_valid;
    logic [2:0] fpu_op;
    logic [4:0] wb_rd;

    fpu_issue_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .fadd        (fadd),
        .fsub        (fsub),
        .fmul        (fmul),
        .fdiv        (fdiv),
        .fsqrt       (fsqrt),
        .issue_valid (issue_valid),
        .rd          (rd),
        .flush       (flush),
        .stall       (stall),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] rd;
        int         cyc;
    } wb_exp_t;

    typedef struct {
        logic [2:0] op;
        int         cyc;
    } st_exp_t;

    wb_exp_t wb_q[$];
    st_exp_t st_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [4:0] f, input logic v, input logic [4:0] r, input logic fl);
        {fsqrt, fdiv, fmul, fsub, fadd} = f;
        issue_valid = v;
        rd          = r;
        flush       = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input logic [2:0] op, input int c);
        st_exp_t e;
        e.op  = op;
        e.cyc = c;
        st_q.push_back(e);
    endtask

    task automatic push_wb(input logic [4:0] r, input int c);
        wb_exp_t e;
        e.rd  = r;
        e.cyc = c;
        wb_q.push_back(e);
    endtask

    // Monitor: every start and writeback must match the next scoreboard entry.
    logic       op_pend = 1'b0;
    logic [2:0] op_exp  = 3'd0;
    wb_exp_t    mon_wb;
    st_exp_t    mon_st;

    always @(negedge clk) begin
        if (op_pend) begin
            chk("fpu_op_latched", int'(fpu_op), int'(op_exp));
            op_pend = 1'b0;
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                chk("unexpected_wb_valid", 1, 0);
            end else begin
                mon_wb = wb_q.pop_front();
                chk("wb_rd", int'(wb_rd), int'(mon_wb.rd));
                chk("wb_cycle", cyc, mon_wb.cyc);
            end
        end
        if (fpu_start) begin
            if (st_q.size() == 0) begin
                chk("unexpected_fpu_start", 1, 0);
            end else begin
                mon_st  = st_q.pop_front();
                chk("start_cycle", cyc, mon_st.cyc);
                op_exp  = mon_st.op;
                op_pend = 1'b1;
            end
        end
    end

    int c0;

    initial begin
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("rst_stall", int'(stall), 0);
        chk("rst_fpu_start", int'(fpu_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_fpu_op", int'(fpu_op), 0);
        chk("rst_wb_rd", int'(wb_rd), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        next_cycle();

        // fadd rd=5: writeback two cycles after issue
        c0 = cyc;
        drive(F_ADD, 1'b1, 5'd5, 1'b0);
        push_start(3'd0, c0);
        push_wb(5'd5, c0 + 2);
        @(negedge clk);
        chk("t1_stall", int'(stall), 0);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (4) next_cycle();

        // fdiv rd=7 then fmul waits under stall, issues from WB
        c0 = cyc;
        drive(F_DIV, 1'b1, 5'd7, 1'b0);
        push_start(3'd3, c0);
        push_wb(5'd7, c0 + 12);
        push_start(3'd2, c0 + 12);
        push_wb(5'd9, c0 + 15);
        next_cycle();
        for (int i = 1; i <= 12; i++) begin
            drive(F_MUL, 1'b1, 5'd9, 1'b0);
            @(negedge clk);
            chk("t2_stall", int'(stall), (i <= 11) ? 1 : 0);
            next_cycle();
        end
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (5) next_cycle();

        // fmul and fdiv together: fdiv wins
        c0 = cyc;
        drive(F_MUL | F_DIV, 1'b1, 5'd3, 1'b0);
        push_start(3'd3, c0);
        push_wb(5'd3, c0 + 12);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (14) next_cycle();

        // fsqrt flushed at cycle 5: no writeback
        c0 = cyc;
        drive(F_SQRT, 1'b1, 5'd4, 1'b0);
        push_start(3'd4, c0);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (4) next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        chk("t4_busy_at_flush", int'(busy), 1);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("t4_busy_after_flush", int'(busy), 0);
        repeat (14) next_cycle();

        // flush in the issue cycle blocks the start
        drive(F_ADD, 1'b1, 5'd11, 1'b1);
        @(negedge clk);
        chk("t4b_start_flushed", int'(fpu_start), 0);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("t4b_busy", int'(busy), 0);
        next_cycle();

        // reset at cycle 4 of fdiv aborts it
        c0 = cyc;
        drive(F_DIV, 1'b1, 5'd12, 1'b0);
        push_start(3'd3, c0);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) next_cycle();
        rst = 1'b1;
        #1;
        chk("t5_rst_stall", int'(stall), 0);
        chk("t5_rst_fpu_start", int'(fpu_start), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_wb_valid", int'(wb_valid), 0);
        chk("t5_rst_fpu_op", int'(fpu_op), 0);
        chk("t5_rst_wb_rd", int'(wb_rd), 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        c0 = cyc;
        drive(F_ADD, 1'b1, 5'd2, 1'b0);
        push_start(3'd0, c0);
        push_wb(5'd2, c0 + 2);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (12) next_cycle();

        // integer instruction during EXEC never stalls
        c0 = cyc;
        drive(F_MUL, 1'b1, 5'd1, 1'b0);
        push_start(3'd2, c0);
        push_wb(5'd1, c0 + 3);
        next_cycle();
        drive(5'b0, 1'b1, 5'd20, 1'b0);
        @(negedge clk);
        chk("t6_int_stall", int'(stall), 0);
        chk("t6_busy", int'(busy), 1);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        repeat (4) next_cycle();

        // flush in WB keeps the writeback but blocks the new issue
        c0 = cyc;
        drive(F_ADD, 1'b1, 5'd6, 1'b0);
        push_start(3'd0, c0);
        push_wb(5'd6, c0 + 2);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        next_cycle();
        drive(F_SUB, 1'b1, 5'd8, 1'b1);
        @(negedge clk);
        chk("t7_wb_valid", int'(wb_valid), 1);
        chk("t7_start_blocked", int'(fpu_start), 0);
        next_cycle();
        drive(5'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("t7_busy", int'(busy), 0);
        repeat (3) next_cycle();

        @(negedge clk);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("start_queue_drained", st_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
